// File: rtl/palette_pkg.sv
// Shared types for the sprite colour palette: shading modes, RGB/entry structs,
// FSM states and the power-on default table.
package palette_pkg;

  typedef enum logic [1:0] {
    SOLID  = 2'd0,
    HGRAD  = 2'd1,
    VGRAD  = 2'd2,
    TRANSP = 2'd3
  } palette_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    palette_mode_t mode;
    rgb_t          rgb;
  } palette_entry_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } pal_state_t;

  // idx0 is the dark-blue sky gradient, idx2 white, everything else black.
  function automatic palette_entry_t default_entry(input int idx);
    palette_entry_t e;
    e.mode = SOLID;
    e.rgb  = '{r: 8'h00, g: 8'h00, b: 8'h00};
    case (idx)
      0: begin
        e.mode = HGRAD;
        e.rgb  = '{r: 8'h00, g: 8'h00, b: 8'h7F};
      end
      2: e.rgb = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/palette_shade.sv
// Combinational per-pixel shader: saturating subtract of a coordinate-derived
// step from each channel, or transparency.
module palette_shade
  import palette_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int GRAD_SHIFT = 3
) (
  input  palette_mode_t        mode_i,
  input  rgb_t                 base_i,
  input  logic [COORD_W-1:0]   x_i,
  input  logic [COORD_W-1:0]   y_i,
  output rgb_t                 rgb_o,
  output logic                 transp_o
);

  // Wide enough that neither operand can reach the sign bit.
  localparam int DW = ((COORD_W > 8) ? COORD_W : 8) + 1;

  logic [COORD_W-1:0] coord;
  logic [DW-1:0]      amt;

  function automatic logic [7:0] sat_sub(input logic [7:0] ch, input logic [DW-1:0] a);
    logic [DW-1:0] diff;
    diff = DW'(ch) - a;
    return diff[DW-1] ? 8'h00 : diff[7:0];
  endfunction

  always_comb begin
    coord    = (mode_i == VGRAD) ? y_i : x_i;
    amt      = DW'(coord >> GRAD_SHIFT);
    rgb_o    = base_i;
    transp_o = 1'b0;
    case (mode_i)
      HGRAD, VGRAD: begin
        rgb_o.r = sat_sub(base_i.r, amt);
        rgb_o.g = sat_sub(base_i.g, amt);
        rgb_o.b = sat_sub(base_i.b, amt);
      end
      TRANSP: begin
        rgb_o    = '0;
        transp_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/palette_lut.sv
// Programmable colour palette: self-loading register table, run-time write port,
// and a 2-stage lookup/shade pipeline.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int GRAD_SHIFT = 3,
  parameter int COORD_W    = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pix_valid_in,
  input  logic [IDX_W-1:0]   color_idx,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               pix_valid_out,
  output logic [7:0]         SP_Red,
  output logic [7:0]         SP_Green,
  output logic [7:0]         SP_Blue,
  output logic               SP_transparent,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [1:0]         wr_mode,
  input  logic [23:0]        wr_rgb,
  output logic               init_done
);

  localparam int DEPTH = 1 << IDX_W;

  palette_entry_t pal_q [DEPTH];

  pal_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               init_done_q;

  // vld_pipe_q[0] = S1 valid, vld_pipe_q[1] = output valid
  logic [1:0]         vld_pipe_q;
  palette_entry_t     s1_ent_q;
  logic [COORD_W-1:0] s1_x_q, s1_y_q;
  logic               s1_init_q;

  rgb_t               shade_rgb;
  logic               shade_transp;
  rgb_t               out_rgb_q;
  logic               out_transp_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      if (state_q == ST_READY) init_done_q <= 1'b1;
    end
  end

  // Table has no reset of its own: INIT reloads every entry after Reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == ST_INIT)
        pal_q[ptr_q] <= default_entry(int'(ptr_q));
      else if (wr_valid)
        pal_q[wr_idx] <= '{mode: palette_mode_t'(wr_mode), rgb: rgb_t'(wr_rgb)};
    end
  end

  // S1 reads the pre-edge table, so a same-cycle write is seen one lookup later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe_q <= '0;
      s1_ent_q   <= '{mode: SOLID, rgb: '0};
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_init_q  <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], pix_valid_in};
      s1_ent_q   <= pal_q[color_idx];
      s1_x_q     <= DrawX;
      s1_y_q     <= DrawY;
      s1_init_q  <= (state_q == ST_INIT);
    end
  end

  palette_shade #(
    .COORD_W   (COORD_W),
    .GRAD_SHIFT(GRAD_SHIFT)
  ) u_shade (
    .mode_i  (s1_ent_q.mode),
    .base_i  (s1_ent_q.rgb),
    .x_i     (s1_x_q),
    .y_i     (s1_y_q),
    .rgb_o   (shade_rgb),
    .transp_o(shade_transp)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_rgb_q    <= '0;
      out_transp_q <= 1'b0;
    end else if (vld_pipe_q[0]) begin
      out_rgb_q    <= s1_init_q ? rgb_t'('0) : shade_rgb;
      out_transp_q <= s1_init_q ? 1'b0 : shade_transp;
    end
  end

  assign pix_valid_out  = vld_pipe_q[1];
  assign SP_Red         = out_rgb_q.r;
  assign SP_Green       = out_rgb_q.g;
  assign SP_Blue        = out_rgb_q.b;
  assign SP_transparent = out_transp_q;
  assign wr_ready       = (state_q == ST_READY);
  assign init_done      = init_done_q;

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: init timing, shading, write port, collisions,
// streaming and mid-burst reset.
module tb_palette_lut;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid_in;
  logic [3:0]  color_idx;
  logic [9:0]  DrawX, DrawY;
  logic        pix_valid_out;
  logic [7:0]  SP_Red, SP_Green, SP_Blue;
  logic        SP_transparent;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_idx;
  logic [1:0]  wr_mode;
  logic [23:0] wr_rgb;
  logic        init_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  palette_lut #(.IDX_W(4), .GRAD_SHIFT(3), .COORD_W(10)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .pix_valid_in  (pix_valid_in),
    .color_idx     (color_idx),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .pix_valid_out (pix_valid_out),
    .SP_Red        (SP_Red),
    .SP_Green      (SP_Green),
    .SP_Blue       (SP_Blue),
    .SP_transparent(SP_transparent),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_idx        (wr_idx),
    .wr_mode       (wr_mode),
    .wr_rgb        (wr_rgb),
    .init_done     (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [23:0] sp_rgb();
    return {SP_Red, SP_Green, SP_Blue};
  endfunction

  // Issue one lookup, then check the result two edges later.
  task automatic lookup(input string tag, input logic [3:0] idx, input logic [9:0] x,
                        input logic [9:0] y, input logic [23:0] exp_rgb, input logic exp_tr);
    @(negedge Clk);
    pix_valid_in = 1'b1; color_idx = idx; DrawX = x; DrawY = y;
    @(negedge Clk);
    pix_valid_in = 1'b0;
    @(negedge Clk);
    chk({tag, ".vld"}, 32'(pix_valid_out), 32'd1);
    chk({tag, ".rgb"}, 32'(sp_rgb()), 32'(exp_rgb));
    chk({tag, ".tr"}, 32'(SP_transparent), 32'(exp_tr));
  endtask

  task automatic write(input logic [3:0] idx, input logic [1:0] mode, input logic [23:0] rgb);
    @(negedge Clk);
    wr_valid = 1'b1; wr_idx = idx; wr_mode = mode; wr_rgb = rgb;
    @(negedge Clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; pix_valid_in = 1'b0; color_idx = '0; DrawX = '0; DrawY = '0;
    wr_valid = 1'b0; wr_idx = '0; wr_mode = '0; wr_rgb = '0;

    @(negedge Clk);
    chk("rst.vld", 32'(pix_valid_out), 32'd0);
    chk("rst.rgb", 32'(sp_rgb()), 32'd0);
    chk("rst.tr", 32'(SP_transparent), 32'd0);
    chk("rst.wr_ready", 32'(wr_ready), 32'd0);
    chk("rst.init_done", 32'(init_done), 32'd0);
    Reset = 1'b0;

    // Edges 1..16 are INIT; wr_ready rises after 16, init_done after 17.
    for (int c = 1; c <= 17; c++) begin
      @(negedge Clk);
      chk($sformatf("init.done%0d", c), 32'(init_done), (c == 17) ? 32'd1 : 32'd0);
      chk($sformatf("init.rdy%0d", c), 32'(wr_ready), (c >= 16) ? 32'd1 : 32'd0);
    end

    lookup("idx2", 4'd2, 10'd100, 10'd0, 24'hFFFFFF, 1'b0);
    lookup("idx0x80", 4'd0, 10'd80, 10'd300, 24'h000075, 1'b0);
    lookup("idx0x639", 4'd0, 10'd639, 10'd0, 24'h000030, 1'b0);
    write(4'd0, 2'd1, 24'h000020);
    lookup("idx0sat", 4'd0, 10'd639, 10'd0, 24'h000000, 1'b0);

    // Same-cycle write and lookup of idx5, then a second lookup.
    @(negedge Clk);
    wr_valid = 1'b1; wr_idx = 4'd5; wr_mode = 2'd0; wr_rgb = 24'h123456;
    pix_valid_in = 1'b1; color_idx = 4'd5; DrawX = '0; DrawY = '0;
    @(negedge Clk);
    wr_valid = 1'b0;
    @(negedge Clk);
    pix_valid_in = 1'b0;
    chk("coll.old.vld", 32'(pix_valid_out), 32'd1);
    chk("coll.old.rgb", 32'(sp_rgb()), 32'h000000);
    @(negedge Clk);
    chk("coll.new.vld", 32'(pix_valid_out), 32'd1);
    chk("coll.new.rgb", 32'(sp_rgb()), 32'h123456);

    // 8 back-to-back lookups: output valid at cycles 2..9 only.
    @(negedge Clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge Clk);
      chk($sformatf("strm.vld%0d", i), 32'(pix_valid_out), (i >= 2 && i < 10) ? 32'd1 : 32'd0);
      pix_valid_in = (i < 8);
      color_idx = 4'd5;
    end
    pix_valid_in = 1'b0;
    chk("strm.rgb", 32'(sp_rgb()), 32'h123456);

    write(4'd3, 2'd3, 24'hABCDEF);
    lookup("transp", 4'd3, 10'd0, 10'd0, 24'h000000, 1'b1);
    write(4'd4, 2'd2, 24'h404040);
    lookup("vgrad", 4'd4, 10'd600, 10'd96, 24'h343434, 1'b0);

    // Reset 3 cycles into a burst.
    @(negedge Clk);
    pix_valid_in = 1'b1; color_idx = 4'd5;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mrst.vld", 32'(pix_valid_out), 32'd0);
    chk("mrst.rdy", 32'(wr_ready), 32'd0);
    chk("mrst.done", 32'(init_done), 32'd0);
    pix_valid_in = 1'b0;
    Reset = 1'b0;
    // Lookup during INIT: valid tracks, colour forced to 0.
    lookup("initlk", 4'd2, 10'd0, 10'd0, 24'h000000, 1'b0);
    repeat (14) @(negedge Clk);
    chk("mrst.done17", 32'(init_done), 32'd1);
    lookup("idx5rst", 4'd5, 10'd0, 10'd0, 24'h000000, 1'b0);
    lookup("idx0rst", 4'd0, 10'd80, 10'd0, 24'h000075, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
